fp_add_sub_pipe: RTL and testbench
==================================

// Module: fp_add_sub_pipe
// PURPOSE
//  Pipelined IEEE-754 add/subtract unit with valid/ready handshakes on both sides.
//  It generalises the single-precision adder to any EXP_BITS/MANT_BITS format, accepts one
//  operation per cycle, and adds RNE rounding, special-value handling, status flags and a tag
//  passthrough. It sits between the FPU issue logic and the result writeback arbiter.
// PARAMETERS
//  EXP_BITS   8    exponent field width (>=3)
//  MANT_BITS  23   stored fraction width (>=4); WIDTH = 1+EXP_BITS+MANT_BITS is a localparam
//  TAG_BITS   4    width of the opaque tag carried with each operation
// PORTS
//  clk               in   1         rising-edge clock
//  reset             in   1         asynchronous, active-low reset
//  in_valid          in   1         operation present on a/b/operation_select/in_tag
//  in_ready          out  1         unit accepts this cycle (transfer = in_valid & in_ready)
//  a, b              in   WIDTH     operands {sign, exp, fraction}
//  operation_select  in   1         0: a+b, 1: a-b
//  in_tag            in   TAG_BITS  returned unchanged with the result
//  out_valid         out  1         result/flags/out_tag valid
//  out_ready         in   1         consumer accepts (transfer = out_valid & out_ready)
//  result            out  WIDTH     rounded sum/difference
//  out_tag           out  TAG_BITS  tag of the operation on result
//  flags             out  4         {NV invalid, OF overflow, UF underflow, NX inexact}
// BEHAVIOUR
//  Reset: all stage valids, out_valid, result, out_tag and flags clear to 0 asynchronously.
//   In-flight operations are discarded. in_ready is 1 on the first cycle after release.
//  Pipeline:
//   S1: unpack; compare magnitudes; swap operands so the larger is first; effective sign of b = b.sign^op.
//    Then align the smaller significand right by the exponent difference.
//    Keep guard, round and sticky bits (sticky = OR of every bit shifted out).
//    A difference >= MANT_BITS+3 gives all-zero plus sticky.
//   S2: add or subtract the (MANT_BITS+4)-bit significands; keep the carry-out.
//   S3: normalise (carry gives a right shift by 1; otherwise shift left by the leading-zero count).
//    Then round to nearest even, renormalise on a rounding carry, pack, and set flags.
//  Latency: exactly 3 cycles from input transfer to out_valid when out_ready is held at 1.
//   Throughput is 1 operation per cycle.
//  Handshake: stage k loads when it is empty or stage k+1 loads. S3 advances when out_ready=1 or out_valid=0.
//   in_ready is 1 when S1 can load; bubbles collapse.
//   While out_valid=1 and out_ready=0, result/out_tag/flags hold stable. Order is strictly FIFO.
//   in_valid with in_ready=0 has no effect; the producer holds its inputs.
//  Special cases (decided in S1, carried through as a bypass):
//   - Any NaN operand gives canonical qNaN {0, all-ones, 1, zeros}; NV=1 only if an operand is an sNaN.
//   - Inf op Inf with effective subtraction gives canonical qNaN, NV=1.
//   - Inf op finite, or same-sign Inf, gives that Inf; no flags.
//   - Subnormal inputs are flushed to signed zero (FTZ); no flag for the flush.
//   - Exact zero from unlike signs gives +0. (-0)+(-0) and (-0)-(+0) give -0.
//  Result exceptions:
//   - Exponent after rounding >= all-ones gives signed Inf, OF=1, NX=1.
//   - Nonzero result with exponent < 1 flushes to signed zero, UF=1, NX=1.
//   - NX=1 whenever any of guard/round/sticky is nonzero.
//  Arithmetic is width-generic: no literal 23/8/32 in datapath logic.
// TESTING
//  1. 0x3F800000 + 0x40000000, op=0, tag=5 -> 0x40400000, flags=0, tag 5, out_valid exactly 3 cycles later.
//  2. 0x3F800000 - 0x3F800000 -> 0x00000000 (+0), flags=0. 0x80000000 + 0x80000000 -> 0x80000000.
//  3. 0x7F800000 - 0x7F800000 -> 0x7FC00000, NV=1. 0x7F800001 + 1.0 -> 0x7FC00000, NV=1.
//  4. 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, OF=1, NX=1. 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, NX=1.
//  5. Push tags 0..5 back-to-back with out_ready=0 for 6 cycles.
//     -> in_ready=0 after 3 accepts; outputs stay stable; then tags drain 0..5 in order with no loss or duplicates.
//  6. Reset pulse (0) with 2 operations in flight.
//     -> out_valid=0 and all outputs 0 immediately; no stale result after release. Rerun with EXP_BITS=11, MANT_BITS=52.

Source files
------------

// File: rtl/fp_add_sub_pipe.sv
// rtl/fp_add_sub_pipe.sv - three-stage IEEE-754 add/subtract with valid/ready, RNE, FTZ, flags and tag
module fp_add_sub_pipe #(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int TAG_BITS  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [EXP_BITS+MANT_BITS:0]   a,
    input  logic [EXP_BITS+MANT_BITS:0]   b,
    input  logic                          operation_select,
    input  logic [TAG_BITS-1:0]           in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_BITS+MANT_BITS:0]   result,
    output logic [TAG_BITS-1:0]           out_tag,
    output logic [3:0]                    flags
);
    localparam int WIDTH = 1 + EXP_BITS + MANT_BITS;
    localparam int SW    = MANT_BITS + 4;             // hidden + fraction + guard/round/sticky
    localparam int LZW   = $clog2(SW + 1);
    localparam int EW    = EXP_BITS + LZW + 1;        // signed working exponent
    localparam logic [EXP_BITS-1:0] EXP_MAX = {EXP_BITS{1'b1}};
    localparam logic [WIDTH-1:0]    QNAN    = {1'b0, EXP_MAX, 1'b1, {(MANT_BITS-1){1'b0}}};

    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        lzc = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) lzc = LZW'(SW - 1 - i);
    endfunction

    // Handshake: each stage loads when empty or when its successor loads
    logic en1, en2, en3;
    logic v1_q, v2_q, out_valid_q;
    assign en3      = ~out_valid_q | out_ready;
    assign en2      = ~v2_q | en3;
    assign en1      = ~v1_q | en2;
    assign in_ready = en1;

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic                  sa, sb, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, swap;
    logic [EXP_BITS-1:0]   ea, eb, big_e, small_e, diff;
    logic [MANT_BITS-1:0]  ma, mb;
    logic [SW-1:0]         sig_small, shifted;
    logic                  sp1_d, spnv1_d, sg1_d, sub1_d;
    logic [WIDTH-1:0]      spres1_d;
    logic [EXP_BITS-1:0]   e1_d;
    logic [SW-1:0]         bs1_d, ss1_d;

    assign sa     = a[WIDTH-1];
    assign sb     = b[WIDTH-1] ^ operation_select;
    assign ea     = a[WIDTH-2:MANT_BITS];
    assign eb     = b[WIDTH-2:MANT_BITS];
    assign ma     = a[MANT_BITS-1:0];
    assign mb     = b[MANT_BITS-1:0];
    assign nan_a  = (ea == EXP_MAX) && (ma != '0);
    assign nan_b  = (eb == EXP_MAX) && (mb != '0);
    assign snan_a = nan_a && !ma[MANT_BITS-1];
    assign snan_b = nan_b && !mb[MANT_BITS-1];
    assign inf_a  = (ea == EXP_MAX) && (ma == '0);
    assign inf_b  = (eb == EXP_MAX) && (mb == '0);
    assign zero_a = (ea == '0);                        // subnormals flush to zero here
    assign zero_b = (eb == '0);
    assign swap   = {ea, zero_a ? '0 : ma} < {eb, zero_b ? '0 : mb};

    // Special-value bypass decision and alignment of the smaller operand
    always_comb begin
        sp1_d    = nan_a | nan_b | inf_a | inf_b | (zero_a & zero_b);
        spnv1_d  = 1'b0;
        spres1_d = '0;
        if (nan_a | nan_b) begin
            spres1_d = QNAN;
            spnv1_d  = snan_a | snan_b;
        end else if (inf_a & inf_b) begin
            if (sa != sb) begin
                spres1_d = QNAN;
                spnv1_d  = 1'b1;
            end else begin
                spres1_d = {sa, EXP_MAX, {MANT_BITS{1'b0}}};
            end
        end else if (inf_a) begin
            spres1_d = {sa, EXP_MAX, {MANT_BITS{1'b0}}};
        end else if (inf_b) begin
            spres1_d = {sb, EXP_MAX, {MANT_BITS{1'b0}}};
        end else begin
            spres1_d = {sa & sb, {(WIDTH-1){1'b0}}};
        end

        sg1_d   = swap ? sb : sa;
        sub1_d  = sa ^ sb;
        big_e   = swap ? eb : ea;
        small_e = swap ? ea : eb;
        e1_d    = big_e;
        bs1_d   = {1'b1, swap ? mb : ma, 3'b000};
        sig_small = (swap ? zero_a : zero_b) ? '0 : {1'b1, swap ? ma : mb, 3'b000};
        diff    = big_e - small_e;
        shifted = sig_small >> diff;
        if (32'(diff) >= 32'(SW - 1))
            ss1_d = {{(SW-1){1'b0}}, |sig_small};
        else
            ss1_d = {shifted[SW-1:1], shifted[0] | (|(sig_small & ~({SW{1'b1}} << diff)))};
    end

    logic                 sp1_q, spnv1_q, sg1_q, sub1_q;
    logic [WIDTH-1:0]     spres1_q;
    logic [EXP_BITS-1:0]  e1_q;
    logic [SW-1:0]        bs1_q, ss1_q;
    logic [TAG_BITS-1:0]  tag1_q;

    // S1 register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q <= 1'b0; sp1_q <= 1'b0; spnv1_q <= 1'b0; sg1_q <= 1'b0; sub1_q <= 1'b0;
            spres1_q <= '0; e1_q <= '0; bs1_q <= '0; ss1_q <= '0; tag1_q <= '0;
        end else if (en1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                sp1_q <= sp1_d; spnv1_q <= spnv1_d; sg1_q <= sg1_d; sub1_q <= sub1_d;
                spres1_q <= spres1_d; e1_q <= e1_d; bs1_q <= bs1_d; ss1_q <= ss1_d; tag1_q <= in_tag;
            end
        end
    end

    // ---------------- S2: significand add/subtract ----------------
    logic [SW:0]          sum2_d, sum2_q;
    logic                 sp2_q, spnv2_q, sg2_q;
    logic [WIDTH-1:0]     spres2_q;
    logic [EXP_BITS-1:0]  e2_q;
    logic [TAG_BITS-1:0]  tag2_q;

    assign sum2_d = sub1_q ? ({1'b0, bs1_q} - {1'b0, ss1_q}) : ({1'b0, bs1_q} + {1'b0, ss1_q});

    // S2 register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2_q <= 1'b0; sp2_q <= 1'b0; spnv2_q <= 1'b0; sg2_q <= 1'b0;
            spres2_q <= '0; e2_q <= '0; sum2_q <= '0; tag2_q <= '0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sp2_q <= sp1_q; spnv2_q <= spnv1_q; sg2_q <= sg1_q;
                spres2_q <= spres1_q; e2_q <= e1_q; sum2_q <= sum2_d; tag2_q <= tag1_q;
            end
        end
    end

    // ---------------- S3: normalise, round, pack, flag ----------------
    logic [SW-1:0]          norm;
    logic [LZW-1:0]         lz;
    logic [EW-1:0]          exp_w, exp_r;
    logic [MANT_BITS+1:0]   rnd;
    logic [MANT_BITS-1:0]   mant;
    logic                   rup, nx;
    logic [WIDTH-1:0]       result_d;
    logic [3:0]             flags_d;

    // Normalisation, round-to-nearest-even and exception packing
    always_comb begin
        lz = lzc(sum2_q[SW-1:0]);
        if (sum2_q[SW]) begin
            norm  = {sum2_q[SW:2], sum2_q[1] | sum2_q[0]};
            exp_w = EW'(e2_q) + EW'(1);
        end else begin
            norm  = sum2_q[SW-1:0] << lz;
            exp_w = EW'(e2_q) - EW'(lz);
        end
        rup = norm[2] & (norm[1] | norm[0] | norm[3]);
        nx  = |norm[2:0];
        rnd = {1'b0, norm[SW-1:3]} + (MANT_BITS+2)'(rup);
        if (rnd[MANT_BITS+1]) begin
            exp_r = exp_w + EW'(1);
            mant  = rnd[MANT_BITS:1];
        end else begin
            exp_r = exp_w;
            mant  = rnd[MANT_BITS-1:0];
        end

        result_d = {sg2_q, exp_r[EXP_BITS-1:0], mant};
        flags_d  = {3'b000, nx};
        if (sp2_q) begin
            result_d = spres2_q;
            flags_d  = {spnv2_q, 3'b000};
        end else if (sum2_q == '0) begin
            result_d = '0;
            flags_d  = 4'b0000;
        end else if (!exp_r[EW-1] && (exp_r >= EW'(EXP_MAX))) begin
            result_d = {sg2_q, EXP_MAX, {MANT_BITS{1'b0}}};
            flags_d  = 4'b0101;
        end else if (exp_r[EW-1] || (exp_r == '0)) begin
            result_d = {sg2_q, {(WIDTH-1){1'b0}}};
            flags_d  = 4'b0011;
        end
    end

    logic [WIDTH-1:0]    result_q;
    logic [TAG_BITS-1:0] tag_q;
    logic [3:0]          flags_q;

    // Output register; holds while the consumer stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0; result_q <= '0; tag_q <= '0; flags_q <= '0;
        end else if (en3) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                result_q <= result_d; tag_q <= tag2_q; flags_q <= flags_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = tag_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// tb/tb_fp_add_sub_pipe.sv - directed self-checking bench for fp_add_sub_pipe (single and double)
module tb_fp_add_sub_pipe;
    logic        clk, reset;
    logic        in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  in_tag, out_tag, flags;

    logic        d_in_valid, d_in_ready, d_op, d_out_valid, d_out_ready;
    logic [63:0] d_a, d_b, d_result;
    logic [3:0]  d_in_tag, d_out_tag, d_flags;

    int checks = 0;
    int errors = 0;

    fp_add_sub_pipe #(.EXP_BITS(8), .MANT_BITS(23), .TAG_BITS(4)) dut_sp (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .operation_select(op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .flags(flags)
    );

    fp_add_sub_pipe #(.EXP_BITS(11), .MANT_BITS(52), .TAG_BITS(4)) dut_dp (
        .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .operation_select(d_op), .in_tag(d_in_tag),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .result(d_result),
        .out_tag(d_out_tag), .flags(d_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic opv, input logic [3:0] tg,
                          input logic [31:0] er, input logic [3:0] ef);
        int cyc;
        a = av; b = bv; op = opv; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, 3);
        check({name, "_result"}, result, er);
        check({name, "_flags"}, flags, ef);
        check({name, "_tag"}, out_tag, tg);
        @(posedge clk); #1;
    endtask

    task automatic run_op_d(input string name, input logic [63:0] av, input logic [63:0] bv,
                            input logic opv, input logic [3:0] tg,
                            input logic [63:0] er, input logic [3:0] ef);
        int cyc;
        d_a = av; d_b = bv; d_op = opv; d_in_tag = tg; d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        cyc = 1;
        while (!d_out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, 3);
        check({name, "_result"}, d_result, er);
        check({name, "_flags"}, d_flags, ef);
        check({name, "_tag"}, d_out_tag, tg);
        @(posedge clk); #1;
    endtask

    initial begin
        int sent, recv, stale;
        reset = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; op = 1'b0; in_tag = '0; out_ready = 1'b1;
        d_in_valid = 1'b0; d_a = '0; d_b = '0; d_op = 1'b0; d_in_tag = '0; d_out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("rel_in_ready", in_ready, 1);

        run_op("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40400000, 4'b0000);
        run_op("sub_eq",    32'h3F800000, 32'h3F800000, 1'b1, 4'd1, 32'h00000000, 4'b0000);
        run_op("negz_add",  32'h80000000, 32'h80000000, 1'b0, 4'd2, 32'h80000000, 4'b0000);
        run_op("negz_subp", 32'h80000000, 32'h00000000, 1'b1, 4'd3, 32'h80000000, 4'b0000);
        run_op("inf_sub",   32'h7F800000, 32'h7F800000, 1'b1, 4'd4, 32'h7FC00000, 4'b1000);
        run_op("snan",      32'h7F800001, 32'h3F800000, 1'b0, 4'd6, 32'h7FC00000, 4'b1000);
        run_op("qnan",      32'h7FC00001, 32'h3F800000, 1'b0, 4'd7, 32'h7FC00000, 4'b0000);
        run_op("inf_fin",   32'h7F800000, 32'h3F800000, 1'b0, 4'd8, 32'h7F800000, 4'b0000);
        run_op("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd9, 32'h7F800000, 4'b0101);
        run_op("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 4'd10, 32'h3F800000, 4'b0001);
        run_op("round_up",  32'h3F800000, 32'h33C00000, 1'b0, 4'd11, 32'h3F800001, 4'b0001);
        run_op("sub_3_1",   32'h40400000, 32'h3F800000, 1'b1, 4'd12, 32'h40000000, 4'b0000);
        run_op("sub_neg",   32'h3F800000, 32'h40000000, 1'b1, 4'd13, 32'hBF800000, 4'b0000);
        run_op("ftz_in",    32'h00000001, 32'h3F800000, 1'b0, 4'd14, 32'h3F800000, 4'b0000);
        run_op("underflow", 32'h00C00000, 32'h00800000, 1'b1, 4'd15, 32'h00000000, 4'b0011);

        // Back-pressure: six back-to-back ops against a stalled consumer
        sent = 0; recv = 0;
        a = 32'h3F800000; b = 32'h40000000; op = 1'b0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            out_ready = (cyc >= 6);
            in_valid  = (sent < 6);
            in_tag    = sent[3:0];
            #1;
            if (cyc == 3) begin
                check("bp_in_ready_full", in_ready, 0);
                check("bp_accepts", sent, 3);
            end
            if (out_valid && !out_ready) begin
                check("bp_hold_result", result, 32'h40400000);
                check("bp_hold_tag", out_tag, 0);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check("bp_drain_tag", out_tag, recv);
                recv++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_sent", sent, 6);
        check("bp_recv", recv, 6);
        @(posedge clk); #1;
        check("bp_empty", out_valid, 0);

        // Reset with the pipeline full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_tag = 4'(7 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_result", result, 0);
        check("async_rst_tag", out_tag, 0);
        check("async_rst_flags", flags, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        check("post_rst_in_ready", in_ready, 1);
        stale = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("no_stale", stale, 0);
        run_op("post_rst_op", 32'h3F800000, 32'h40000000, 1'b0, 4'd3, 32'h40400000, 4'b0000);

        // Double precision
        run_op_d("dp_add_1_2", 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 4'd1, 64'h4008000000000000, 4'b0000);
        run_op_d("dp_sub_eq",  64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 4'd2, 64'h0, 4'b0000);
        run_op_d("dp_ovf",     64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 4'd3, 64'h7FF0000000000000, 4'b0101);
        run_op_d("dp_snan",    64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 4'd4, 64'h7FF8000000000000, 4'b1000);
        run_op_d("dp_tie",     64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 4'd5, 64'h3FF0000000000000, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
